card_shoe: RTL and testbench

CARD_SHOE -- requirements
Module: card_shoe

---
 rtl/card_shoe_pkg.sv | 33 +++
 rtl/card_shoe_lfsr16.sv | 31 +++
 rtl/card_shoe.sv | 135 +++++++++++++
 tb/tb_card_shoe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_shoe_pkg.sv
// rtl/card_shoe_pkg.sv - shared card shoe types, constants and card value helper
// Purpose: state encoding, deck size, default seed and the rank-to-value
//          mapping shared between the shoe and the blackjack controller.
// Ports:   none (package).
package card_shoe_pkg;

  typedef enum logic [2:0] {
    INIT,
    SHUF,
    LOAD,
    READY,
    SERVE,
    DONE
  } state_t;

  localparam int          DECK_SIZE = 52;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;

  // Blackjack value of a card index (suit*13+rank): ace=11, 2..9 face value,
  // ten and court cards = 10.
  function automatic logic [4:0] card_value(input logic [5:0] card);
    logic [5:0] rank;
    rank = card % 6'd13;
    if (rank == 6'd0) begin
      return 5'd11;
    end else if (rank <= 6'd8) begin
      return 5'(rank + 6'd1);
    end else begin
      return 5'd10;
    end
  endfunction

endpackage

// File: rtl/card_shoe_lfsr16.sv
// rtl/card_shoe_lfsr16.sv - 16-bit maximal-length Galois LFSR for the shuffle
// Purpose: pseudo-random source, polynomial x^16+x^14+x^13+x^11+1.
// Ports:   CLK   clock
//          RST   synchronous active-high reset, loads RST_VAL
//          load  load seed (wins over step)
//          seed  value loaded on load
//          step  advance one state
//          q     current LFSR state
module lfsr16 #(
  parameter logic [15:0] RST_VAL = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  // Right-shifting Galois form: taps 16,14,13,11 fold into mask 16'hB400.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - register-based shuffled card shoe with one-at-a-time dealing
// Purpose: builds a deck, Fisher-Yates shuffles it with an LFSR, then presents
//          one card at a time to a consumer.
// Ports:   CLK        clock
//          RST        synchronous active-high reset
//          SHUFFLE    restart build+shuffle using SEED
//          SEED       LFSR seed (16'h0000 selects DEF_SEED)
//          card_used  consumer takes the presented card (only when RDY=1)
//          RDY        a card is presented on CARD/VALUE
//          CARD       card index 0..51 = suit*13+rank
//          VALUE      blackjack value of CARD
//          REMAIN     undealt cards including the presented one
//          EMPTY      deck exhausted
module card_shoe
  import card_shoe_pkg::*;
#(
  parameter int          DECK_SIZE = card_shoe_pkg::DECK_SIZE,
  parameter logic [15:0] DEF_SEED  = card_shoe_pkg::DEF_SEED
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SHUFFLE,
  input  logic [15:0] SEED,
  input  logic        card_used,
  output logic        RDY,
  output logic [5:0]  CARD,
  output logic [4:0]  VALUE,
  output logic [5:0]  REMAIN,
  output logic        EMPTY
);

  localparam logic [5:0] FULL = 6'(DECK_SIZE);
  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);

  state_t      state;
  logic [5:0]  deck [DECK_SIZE];
  logic [5:0]  ptr;
  logic [5:0]  idx;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_seed;
  logic [5:0]  j;

  assign lfsr_seed = (SEED == 16'h0000) ? DEF_SEED : SEED;

  // Swap partner: scale the LFSR value into 0..idx without a divider.
  assign j = 6'((22'(lfsr_q) * (22'(idx) + 22'd1)) >> 16);

  lfsr16 #(
    .RST_VAL(DEF_SEED)
  ) u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .load (SHUFFLE),
    .seed (lfsr_seed),
    .step (state == SHUF),
    .q    (lfsr_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= INIT;
      ptr    <= '0;
      idx    <= '0;
      RDY    <= 1'b0;
      EMPTY  <= 1'b0;
      CARD   <= '0;
      VALUE  <= '0;
      REMAIN <= '0;
    end else if (SHUFFLE) begin
      // Abort whatever is in progress, including a same-cycle card_used.
      state  <= INIT;
      ptr    <= '0;
      idx    <= '0;
      RDY    <= 1'b0;
      EMPTY  <= 1'b0;
      REMAIN <= '0;
    end else begin
      case (state)
        INIT: begin
          deck[idx] <= idx;
          if (idx == LAST) begin
            state <= SHUF;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        SHUF: begin
          // j == idx writes the same value twice, a harmless no-op swap.
          deck[idx] <= deck[j];
          deck[j]   <= deck[idx];
          if (idx == 6'd1) begin
            state <= LOAD;
          end else begin
            idx <= idx - 6'd1;
          end
        end
        LOAD: begin
          ptr    <= '0;
          CARD   <= deck[0];
          VALUE  <= card_value(deck[0]);
          REMAIN <= FULL;
          RDY    <= 1'b1;
          state  <= READY;
        end
        READY: begin
          if (card_used) begin
            ptr   <= ptr + 6'd1;
            RDY   <= 1'b0;
            state <= SERVE;
          end
        end
        SERVE: begin
          if (ptr == FULL) begin
            EMPTY  <= 1'b1;
            REMAIN <= '0;
            state  <= DONE;
          end else begin
            CARD   <= deck[ptr];
            VALUE  <= card_value(deck[ptr]);
            REMAIN <= FULL - ptr;
            RDY    <= 1'b1;
            state  <= READY;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// tb/tb_card_shoe.sv - self-checking bench for card_shoe against a deck model
module tb_card_shoe;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SHUFFLE;
  logic [15:0] SEED;
  logic        card_used;
  logic        RDY;
  logic [5:0]  CARD;
  logic [4:0]  VALUE;
  logic [5:0]  REMAIN;
  logic        EMPTY;

  int tests = 0;
  int fails = 0;
  int exp_deck [52];

  card_shoe dut (
    .CLK       (CLK),
    .RST       (RST),
    .SHUFFLE   (SHUFFLE),
    .SEED      (SEED),
    .card_used (card_used),
    .RDY       (RDY),
    .CARD      (CARD),
    .VALUE     (VALUE),
    .REMAIN    (REMAIN),
    .EMPTY     (EMPTY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_value(input int c);
    int r;
    r = c % 13;
    if (r == 0) return 11;
    if (r <= 8) return r + 1;
    return 10;
  endfunction

  // Deck order the shoe should produce: identity deck, Fisher-Yates from the
  // top down, swap index from the LFSR scaled to 0..i, LFSR advanced per swap.
  task automatic build_model(input logic [15:0] seed);
    int s, jj, t;
    s = (seed == 16'h0000) ? 32'hACE1 : int'(seed);
    for (int k = 0; k < 52; k++) exp_deck[k] = k;
    for (int i = 51; i >= 1; i--) begin
      jj = (s * (i + 1)) / 65536;
      t = exp_deck[i];
      exp_deck[i] = exp_deck[jj];
      exp_deck[jj] = t;
      s = ((s % 2) == 1) ? ((s / 2) ^ 32'hB400) : (s / 2);
    end
  endtask

  // Called at the sample point right after the edge that took RST/SHUFFLE.
  task automatic wait_ready(input string tag);
    int first;
    first = -1;
    tests++;
    if (EMPTY !== 1'b0) begin
      fails++;
      $display("FAIL %s_empty_clear: got %0b expected 0", tag, EMPTY);
    end
    for (int k = 0; k < 300; k++) begin
      if (k > 0) begin
        @(posedge CLK); #1;
      end
      if (RDY === 1'b1) begin
        first = k;
        break;
      end
      card_used = 1'($urandom_range(0, 1));
    end
    card_used = 1'b0;
    tests++;
    if (first != 104) begin
      fails++;
      $display("FAIL %s_rdy_latency: got %0d expected 104 (cycle 105)", tag, first);
    end
    tests++;
    if (REMAIN !== 6'd52) begin
      fails++;
      $display("FAIL %s_remain_full: got %0d expected 52", tag, REMAIN);
    end
    tests++;
    if (CARD !== 6'(exp_deck[0])) begin
      fails++;
      $display("FAIL %s_first_card: got %0d expected %0d", tag, CARD, exp_deck[0]);
    end
  endtask

  task automatic deal(input bit hold, input int stop_at);
    int n, cyc, nseen;
    bit prev_rdy, prev_used, after_serve;
    logic [5:0] prev_card;
    bit seen [52];
    n = 0; cyc = 0; prev_rdy = 0; prev_used = 0; after_serve = 0; prev_card = '0;
    for (int k = 0; k < 52; k++) seen[k] = 0;
    while (cyc < 1500) begin
      if (after_serve && hold && n < 52) begin
        tests++;
        if (RDY !== 1'b1) begin
          fails++;
          $display("FAIL hold_rate: card %0d RDY got %0b expected 1", n, RDY);
        end
      end
      after_serve = 0;
      if (prev_rdy && prev_used) begin
        if (prev_card < 6'd52) seen[prev_card] = 1;
        n++;
        after_serve = 1;
        tests++;
        if (RDY !== 1'b0) begin
          fails++;
          $display("FAIL serve_gap: after card %0d RDY got %0b expected 0", n, RDY);
        end
      end
      if (RDY === 1'b1 && n < 52) begin
        tests++;
        if (CARD !== 6'(exp_deck[n])) begin
          fails++;
          $display("FAIL card_%0d: got %0d expected %0d", n, CARD, exp_deck[n]);
        end
        tests++;
        if (VALUE !== 5'(exp_value(exp_deck[n]))) begin
          fails++;
          $display("FAIL value_%0d: card %0d got %0d expected %0d", n, CARD, VALUE,
                   exp_value(exp_deck[n]));
        end
        tests++;
        if (REMAIN !== 6'(52 - n)) begin
          fails++;
          $display("FAIL remain_%0d: got %0d expected %0d", n, REMAIN, 52 - n);
        end
      end
      if (n == stop_at && (stop_at == 52 || RDY === 1'b1)) break;
      card_used = hold ? 1'b1 : 1'($urandom_range(0, 1));
      prev_rdy = (RDY === 1'b1);
      prev_used = card_used;
      prev_card = CARD;
      @(posedge CLK); #1;
      cyc++;
    end
    card_used = 1'b0;
    tests++;
    if (n != stop_at) begin
      fails++;
      $display("FAIL deal_timeout: dealt %0d expected %0d", n, stop_at);
    end
    if (stop_at == 52) begin
      nseen = 0;
      for (int k = 0; k < 52; k++) nseen += seen[k] ? 1 : 0;
      tests++;
      if (nseen != 52) begin
        fails++;
        $display("FAIL distinct_cards: got %0d expected 52", nseen);
      end
    end
  endtask

  task automatic check_done(input string tag);
    @(posedge CLK); #1;
    tests++;
    if (RDY !== 1'b0 || EMPTY !== 1'b1 || REMAIN !== 6'd0) begin
      fails++;
      $display("FAIL %s_done: RDY=%0b EMPTY=%0b REMAIN=%0d expected 0/1/0", tag, RDY, EMPTY, REMAIN);
    end
    tests++;
    if (CARD !== 6'(exp_deck[51]) || VALUE !== 5'(exp_value(exp_deck[51]))) begin
      fails++;
      $display("FAIL %s_done_hold: CARD=%0d VALUE=%0d expected %0d/%0d", tag, CARD, VALUE,
               exp_deck[51], exp_value(exp_deck[51]));
    end
    card_used = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    card_used = 1'b0;
    tests++;
    if (RDY !== 1'b0 || EMPTY !== 1'b1 || REMAIN !== 6'd0) begin
      fails++;
      $display("FAIL %s_done_sticky: RDY=%0b EMPTY=%0b REMAIN=%0d expected 0/1/0", tag, RDY, EMPTY, REMAIN);
    end
  endtask

  task automatic do_shuffle(input logic [15:0] seed);
    SEED = seed;
    SHUFFLE = 1'b1;
    @(posedge CLK); #1;
    SHUFFLE = 1'b0;
    SEED = 16'($urandom);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    tests++;
    if (RDY !== 1'b0 || EMPTY !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: RDY=%0b EMPTY=%0b expected 0/0", RDY, EMPTY);
    end
    tests++;
    if (CARD !== 6'd0 || VALUE !== 5'd0 || REMAIN !== 6'd0) begin
      fails++;
      $display("FAIL reset_outputs: CARD=%0d VALUE=%0d REMAIN=%0d expected 0/0/0", CARD, VALUE, REMAIN);
    end
    RST = 1'b0;
    build_model(16'hACE1);
    wait_ready("reset");
  endtask

  task automatic test_deal_all();
    deal(1'b0, 52);
    check_done("deal_all");
  endtask

  task automatic test_seed_repeat();
    for (int run = 0; run < 2; run++) begin
      build_model(16'h1234);
      do_shuffle(16'h1234);
      wait_ready("seed1234");
      deal(run == 0, 52);
      check_done("seed1234");
    end
  endtask

  task automatic test_seed_zero();
    build_model(16'hACE1);
    do_shuffle(16'h0000);
    wait_ready("seed0");
    deal(1'b0, 52);
    check_done("seed0");
  endtask

  task automatic test_random_seeds();
    logic [15:0] s;
    for (int r = 0; r < 2; r++) begin
      s = 16'($urandom);
      build_model(s);
      do_shuffle(s);
      wait_ready("rand_seed");
      deal(1'b0, 52);
      check_done("rand_seed");
    end
  endtask

  task automatic test_shuffle_collision();
    logic [15:0] s;
    s = 16'($urandom_range(1, 65535));
    build_model(s);
    do_shuffle(s);
    wait_ready("collide_pre");
    deal(1'b0, 22);
    tests++;
    if (REMAIN !== 6'd30) begin
      fails++;
      $display("FAIL collide_remain30: got %0d expected 30", REMAIN);
    end
    s = 16'($urandom_range(1, 65535));
    build_model(s);
    SEED = s;
    SHUFFLE = 1'b1;
    card_used = 1'b1;
    @(posedge CLK); #1;
    SHUFFLE = 1'b0;
    card_used = 1'b0;
    tests++;
    if (RDY !== 1'b0) begin
      fails++;
      $display("FAIL collide_rdy_drop: got %0b expected 0", RDY);
    end
    wait_ready("collide");
    deal(1'b0, 52);
    check_done("collide");
  endtask

  task automatic test_reset_mid();
    build_model(16'h1234);
    do_shuffle(16'h1234);
    repeat (70) @(posedge CLK);
    #1;
    RST = 1'b1;
    SHUFFLE = 1'b1;
    SEED = 16'h5555;
    card_used = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    SHUFFLE = 1'b0;
    card_used = 1'b0;
    tests++;
    if (CARD !== 6'd0 || REMAIN !== 6'd0 || RDY !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: CARD=%0d REMAIN=%0d RDY=%0b expected 0/0/0", CARD, REMAIN, RDY);
    end
    build_model(16'hACE1);
    wait_ready("reset_mid");
    deal(1'b1, 52);
    check_done("reset_mid");
  endtask

  initial begin
    RST = 1'b1;
    SHUFFLE = 1'b0;
    SEED = 16'h0000;
    card_used = 1'b0;
    test_reset();
    test_deal_all();
    test_seed_repeat();
    test_seed_zero();
    test_random_seeds();
    test_shuffle_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
